uart_rx: RTL and testbench

//   Serial UART receiver with 16x oversampling. It recovers DBIT-bit LSB-first frames
//   (1 start, DBIT data, 1 stop) from the asynchronous rx line, using the shared baud

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx : 16x-oversampled UART receiver, DBIT data bits LSB first, 1 stop bit
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       s_tick_i,
  input  logic       rx_i,
  output logic [7:0] dout_o,
  output logic       rx_done_tick_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] dout_q, dout_d;
  logic       done_q, done_d;
  logic       ferr_q, ferr_d;
  logic       busy_q, busy_d;
  logic       armed_q, armed_d;
  logic       rx_meta_q, rx_s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      s_q       <= 4'd0;
      n_q       <= 3'd0;
      shift_q   <= 8'd0;
      dout_q    <= 8'd0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
      armed_q   <= armed_d;
    end
  end

  // armed_q records a high line since the last stop sample, so a held-low
  // break cannot retrigger a new frame on its own.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    armed_d = armed_q;
    unique case (state_q)
      IDLE: begin
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          s_d     = 4'd0;
        end
      end
      START: begin
        if (s_tick_i) begin
          if (s_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = 4'd0;
              n_d     = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick_i) begin
          if (s_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            s_d     = 4'd0;
            if (n_q == 3'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick_i) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            state_d = IDLE;
            dout_d  = shift_q >> (8 - DBIT);
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
            armed_d = rx_s_q;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign dout_o         = dout_q;
  assign rx_done_tick_o = done_q;
  assign frame_err_o    = ferr_q;
  assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx : randomized frames for DBIT=8 and DBIT=7 receivers, checked
// against a frame-level queue model of what each receiver must deliver.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic       s_tick;
  logic       rx_w   [2];
  logic [7:0] dout_w [2];
  logic       done_w [2];
  logic       ferr_w [2];
  logic       busy_w [2];

  frame_t     exp_q  [2][$];
  logic [7:0] last_d [2];
  logic       last_fe[2];
  int         pulses [2];
  int         checks;
  int         failures;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .s_tick_i(s_tick), .rx_i(rx_w[0]),
    .dout_o(dout_w[0]), .rx_done_tick_o(done_w[0]),
    .frame_err_o(ferr_w[0]), .busy_o(busy_w[0])
  );

  uart_rx #(.DBIT(7), .SB_TICK(16)) dut7 (
    .clk_i(clk), .rst_ni(rst_n), .s_tick_i(s_tick), .rx_i(rx_w[1]),
    .dout_o(dout_w[1]), .rx_done_tick_o(done_w[1]),
    .frame_err_o(ferr_w[1]), .busy_o(busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int tcnt;
    tcnt   = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt   = (tcnt + 1) % 4;
      s_tick = (tcnt == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk("reset_dout", dout_w[k], 0);
        chk("reset_done", done_w[k], 0);
        chk("reset_ferr", ferr_w[k], 0);
        chk("reset_busy", busy_w[k], 0);
        last_d[k]  = 8'd0;
        last_fe[k] = 1'b0;
      end else if (done_w[k]) begin
        pulses[k]++;
        chk("pulse_expected", exp_q[k].size() != 0, 1);
        chk("busy_at_done", busy_w[k], 0);
        if (exp_q[k].size() != 0) begin
          frame_t f;
          f = exp_q[k].pop_front();
          chk("frame_dout", dout_w[k], f.d);
          chk("frame_ferr", ferr_w[k], f.fe);
          last_d[k]  = f.d;
          last_fe[k] = f.fe;
        end
      end else begin
        chk("hold_dout", dout_w[k], last_d[k]);
        chk("hold_ferr", ferr_w[k], last_fe[k]);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // abort_bit >= 0 stops mid data bit abort_bit and expects no delivery
  task automatic send_frame(input int k, input logic [7:0] data, input int nbits,
                            input bit bad_stop, input int abort_bit);
    frame_t     f;
    logic [7:0] mask;
    mask = 8'((1 << nbits) - 1);
    f.d  = data & mask;
    f.fe = bad_stop;
    if (abort_bit < 0) exp_q[k].push_back(f);
    rx_w[k] = 1'b0;
    wait_clk(64);
    for (int i = 0; i < nbits; i++) begin
      rx_w[k] = data[i];
      if (i == abort_bit) begin
        wait_clk(32);
        return;
      end
      wait_clk(64);
    end
    rx_w[k] = ~bad_stop;
    wait_clk(64);
    rx_w[k] = 1'b1;
  endtask

  task automatic check_idle(input int k);
    chk("frame_delivered", exp_q[k].size(), 0);
    chk("busy_after_frame", busy_w[k], 0);
  endtask

  initial begin
    logic [7:0] d;
    bit         bad;
    int         gap;
    int         p0;
    checks   = 0;
    failures = 0;
    pulses   = '{0, 0};
    last_d   = '{8'd0, 8'd0};
    last_fe  = '{1'b0, 1'b0};
    rst_n    = 1'b0;
    rx_w     = '{1'b1, 1'b1};
    wait_clk(5);
    chk("rst_dout_lit", dout_w[0], 8'h00);
    chk("rst_busy_lit", busy_w[0], 0);
    rst_n = 1'b1;
    wait_clk(20);

    p0 = pulses[0];
    send_frame(0, 8'hA5, 8, 0, -1);
    check_idle(0);
    chk("t1_dout", dout_w[0], 8'hA5);
    chk("t1_ferr", ferr_w[0], 0);
    chk("t1_pulses", pulses[0] - p0, 1);
    wait_clk(37);

    p0 = pulses[0];
    rx_w[0] = 1'b0;
    wait_clk(24);
    rx_w[0] = 1'b1;
    wait_clk(80);
    chk("glitch_no_pulse", pulses[0] - p0, 0);
    chk("glitch_busy", busy_w[0], 0);
    chk("glitch_dout", dout_w[0], 8'hA5);

    send_frame(0, 8'h3C, 8, 1, -1);
    check_idle(0);
    chk("t3_dout", dout_w[0], 8'h3C);
    chk("t3_ferr", ferr_w[0], 1);
    wait_clk(16);
    send_frame(0, 8'h81, 8, 0, -1);
    check_idle(0);
    chk("t3_good_ferr", ferr_w[0], 0);
    wait_clk(9);

    p0 = pulses[0];
    send_frame(0, 8'h00, 8, 0, -1);
    send_frame(0, 8'hFF, 8, 0, -1);
    send_frame(0, 8'h55, 8, 0, -1);
    check_idle(0);
    chk("b2b_pulses", pulses[0] - p0, 3);
    chk("b2b_last", dout_w[0], 8'h55);
    wait_clk(30);

    send_frame(1, 8'h5A, 7, 0, -1);
    check_idle(1);
    chk("d7_dout", dout_w[1], 8'h5A);
    chk("d7_msb", dout_w[1][7], 0);
    wait_clk(30);

    p0 = pulses[0];
    exp_q[0].push_back('{d: 8'h00, fe: 1'b1});
    rx_w[0] = 1'b0;
    wait_clk(64 * 12);
    rx_w[0] = 1'b1;
    wait_clk(128);
    chk("break_pulses", pulses[0] - p0, 1);
    chk("break_ferr", ferr_w[0], 1);
    chk("break_dout", dout_w[0], 8'h00);
    send_frame(0, 8'h6E, 8, 0, -1);
    check_idle(0);
    wait_clk(11);

    p0 = pulses[0];
    send_frame(0, 8'hC3, 8, 0, 4);
    rst_n = 1'b0;
    rx_w[0] = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    wait_clk(4);
    chk("abort_dout", dout_w[0], 8'h00);
    chk("abort_busy", busy_w[0], 0);
    rst_n = 1'b1;
    wait_clk(20);
    send_frame(0, 8'h12, 8, 0, -1);
    check_idle(0);
    chk("abort_pulses", pulses[0] - p0, 1);
    chk("t6_dout", dout_w[0], 8'h12);
    wait_clk(13);

    for (int i = 0; i < 16; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(0, d, 8, bad, -1);
      check_idle(0);
      gap = $urandom_range(0, 90);
      if (bad && gap < 8) gap = 8;
      wait_clk(gap);
    end

    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(1, d, 7, bad, -1);
      check_idle(1);
      gap = $urandom_range(0, 60);
      if (bad && gap < 8) gap = 8;
      wait_clk(gap);
    end

    wait_clk(100);
    chk("end_q8_empty", exp_q[0].size(), 0);
    chk("end_q7_empty", exp_q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
